// File: rtl/bbox_sample_iter.sv
// bbox_sample_iter: walks a snapped screen-space bounding box in row-major
// order and emits one candidate sample location per clock, at a stride set
// by the one-hot multisample rate. The upstream pipeline is held off with
// halt_RnnnnH while a box is being walked. There is a single register stage
// between the R13 inputs and the R14 outputs.
// Optional feature: define SAMPLE_ITER_PERF_EN to add a 32-bit free-running
// count of emitted samples on sampleCount_R14U.
module bbox_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnH,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
`ifdef SAMPLE_ITER_PERF_EN
    ,
    output logic        [31:0]       sampleCount_R14U
`endif
);

    typedef enum logic {WAIT, TEST} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    valid_nxt;
    logic                    accept;
    logic                    advance;
    logic                    last_x;
    logic                    last_y;
    logic                    in_single;
    logic signed [SIGFIG-1:0] step;
    logic signed [SIGFIG-1:0] ll_x;
    logic signed [SIGFIG-1:0] ll_y;
    logic signed [SIGFIG-1:0] ur_x;
    logic signed [SIGFIG-1:0] ur_y;

    // Sample stride for a one-hot rate; unknown codes fall back to 1 sample/pixel.
    function automatic logic signed [SIGFIG-1:0] step_of(input logic [3:0] rate);
        case (rate)
            4'b0100: step_of = SIGFIG'(1) << (RADIX - 1);
            4'b0010: step_of = SIGFIG'(1) << (RADIX - 2);
            4'b0001: step_of = SIGFIG'(1) << (RADIX - 3);
            default: step_of = SIGFIG'(1) << RADIX;
        endcase
    endfunction

    assign step = step_of(subSample_RnnnnU);

    // Next-state, halt and accept decode; an inverted box on either axis
    // collapses to its LL corner so it never enters the walk.
    always_comb begin
        state_nxt   = state;
        valid_nxt   = 1'b0;
        accept      = 1'b0;
        advance     = 1'b0;
        halt_RnnnnH = 1'b0;
        last_x      = (sample_R14S[0] >= ur_x);
        last_y      = (sample_R14S[1] >= ur_y);
        in_single   = (box_R13S[1][0] <  box_R13S[0][0]) ||
                      (box_R13S[1][1] <  box_R13S[0][1]) ||
                      ((box_R13S[1][0] <= box_R13S[0][0]) &&
                       (box_R13S[1][1] <= box_R13S[0][1]));
        if ((state == TEST) && !(last_x && last_y)) begin
            halt_RnnnnH = 1'b1;
            advance     = 1'b1;
            valid_nxt   = 1'b1;
        end else if (validTri_R13H) begin
            accept    = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = in_single ? WAIT : TEST;
        end else begin
            state_nxt = WAIT;
        end
    end

    // State and sample-valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WAIT;
            validSamp_R14H <= 1'b0;
        end else begin
            state          <= state_nxt;
            validSamp_R14H <= valid_nxt;
        end
    end

    // Triangle/box latch on accept, row-major sample stepping while walking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    tri_R14S[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                color_R14U[c] <= '0;
            sample_R14S[0] <= '0;
            sample_R14S[1] <= '0;
            ll_x           <= '0;
            ll_y           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
        end else if (accept) begin
            tri_R14S       <= tri_R13S;
            color_R14U     <= color_R13U;
            ll_x           <= box_R13S[0][0];
            ll_y           <= box_R13S[0][1];
            ur_x           <= box_R13S[1][0];
            ur_y           <= box_R13S[1][1];
            sample_R14S[0] <= box_R13S[0][0];
            sample_R14S[1] <= box_R13S[0][1];
        end else if (advance) begin
            if (!last_x) begin
                sample_R14S[0] <= sample_R14S[0] + step;
            end else begin
                sample_R14S[0] <= ll_x;
                sample_R14S[1] <= sample_R14S[1] + step;
            end
        end
    end

`ifdef SAMPLE_ITER_PERF_EN
    // Count of cycles that carried a valid sample, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst)
            sampleCount_R14U <= '0;
        else if (validSamp_R14H)
            sampleCount_R14U <= sampleCount_R14U + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Self-checking bench for bbox_sample_iter: a table of boxes with known
// sample counts and final samples, hand sequences for back-to-back triangles
// and reset mid-walk, then randomized boxes against a queue-based model that
// enumerates each box's samples row by row.
module tb_bbox_sample_iter;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] tri_in [3][3];
    logic        [23:0] color_in [3];
    logic signed [23:0] box_in [2][2];
    logic               valid_tri;
    logic        [3:0]  rate_in;
    logic               halt_RnnnnH;
    logic signed [23:0] tri_R14S [3][3];
    logic        [23:0] color_R14U [3];
    logic signed [23:0] sample_R14S [2];
    logic               validSamp_R14H;
`ifdef SAMPLE_ITER_PERF_EN
    logic        [31:0] sampleCount_R14U;
`endif

    bbox_sample_iter dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (rate_in),
        .halt_RnnnnH      (halt_RnnnnH),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
`ifdef SAMPLE_ITER_PERF_EN
        ,
        .sampleCount_R14U (sampleCount_R14U)
`endif
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    // reference model state
    int                 qx[$];
    int                 qy[$];
    bit                 cur_valid = 0;
    bit                 cur_last  = 1;
    int                 cur_x = 0;
    int                 cur_y = 0;
    bit                 chk_zero = 0;
    bit                 accepted = 0;
    logic signed [23:0] exp_tri [3][3];
    logic        [23:0] exp_color [3];
    logic        [31:0] exp_cnt = 0;

    // observed stream statistics for table checks
    int dut_cnt = 0;
    int dut_lx  = 0;
    int dut_ly  = 0;

    typedef struct {
        int         llx;
        int         lly;
        int         urx;
        int         ury;
        logic [3:0] rate;
        int         n;
        int         lx;
        int         ly;
    } vec_t;
    vec_t tbl [10];

    task automatic cmp(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_step(input logic [3:0] r);
        case (r)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Enumerate every sample of a box, row-major; inverted boxes give LL only.
    task automatic build_box();
        int llx, lly, urx, ury, st;
        llx = box_in[0][0];
        lly = box_in[0][1];
        urx = box_in[1][0];
        ury = box_in[1][1];
        st  = model_step(rate_in);
        qx.delete();
        qy.delete();
        if (urx < llx || ury < lly) begin
            qx.push_back(llx);
            qy.push_back(lly);
        end else begin
            for (int y = lly; y <= ury; y += st)
                for (int x = llx; x <= urx; x += st) begin
                    qx.push_back(x);
                    qy.push_back(y);
                end
        end
    endtask

    task automatic pop_sample();
        cur_x     = qx.pop_front();
        cur_y     = qy.pop_front();
        cur_valid = 1;
        cur_last  = (qx.size() == 0);
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_update();
        accepted = 0;
        if (rst) begin
            qx.delete();
            qy.delete();
            cur_valid = 0;
            cur_last  = 1;
            cur_x     = 0;
            cur_y     = 0;
            chk_zero  = 1;
            exp_cnt   = 0;
            for (int v = 0; v < 3; v++) begin
                exp_color[v] = '0;
                for (int a = 0; a < 3; a++) exp_tri[v][a] = '0;
            end
        end else begin
            chk_zero = 0;
            if (cur_valid) exp_cnt = exp_cnt + 32'd1;
            if (valid_tri && !(cur_valid && !cur_last)) begin
                accepted  = 1;
                exp_tri   = tri_in;
                exp_color = color_in;
                build_box();
                pop_sample();
            end else if (qx.size() > 0) begin
                pop_sample();
            end else begin
                cur_valid = 0;
            end
        end
    endtask

    task automatic check();
        bit ok;
        cmp("valid", validSamp_R14H, cur_valid);
        cmp("halt", halt_RnnnnH, cur_valid && !cur_last);
        if (cur_valid || chk_zero) begin
            cmp("sample_x", sample_R14S[0], cur_x);
            cmp("sample_y", sample_R14S[1], cur_y);
            ok = 1;
            for (int v = 0; v < 3; v++) begin
                if (color_R14U[v] !== exp_color[v]) ok = 0;
                for (int a = 0; a < 3; a++)
                    if (tri_R14S[v][a] !== exp_tri[v][a]) ok = 0;
            end
            cmp("tri_color", ok, 1);
        end
`ifdef SAMPLE_ITER_PERF_EN
        cmp("sample_count", sampleCount_R14U, exp_cnt);
`endif
        if (validSamp_R14H === 1'b1) begin
            dut_cnt++;
            dut_lx = sample_R14S[0];
            dut_ly = sample_R14S[1];
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        check();
    endtask

    // Present a triangle and hold it until the edge that accepts it.
    task automatic send(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] rate);
        int n = 0;
        rate_in      = rate;
        box_in[0][0] = 24'(llx);
        box_in[0][1] = 24'(lly);
        box_in[1][0] = 24'(urx);
        box_in[1][1] = 24'(ury);
        for (int v = 0; v < 3; v++) begin
            color_in[v] = 24'($urandom);
            for (int a = 0; a < 3; a++) tri_in[v][a] = 24'($urandom);
        end
        valid_tri = 1;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) cmp("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        valid_tri = 0;
        while ((cur_valid || qx.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) cmp("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        logic [3:0] rates [4];
        logic [3:0] cur_rate;

        tbl[0] = '{32'h400, 32'h800, 32'h400, 32'h800, 4'b1000, 1, 32'h400, 32'h800};
        tbl[1] = '{0, 0, 32'h400, 32'h400, 4'b1000, 4, 32'h400, 32'h400};
        tbl[2] = '{0, 0, 32'h400, 32'h400, 4'b0100, 9, 32'h400, 32'h400};
        tbl[3] = '{32'h400, 32'h400, 0, 0, 4'b1000, 1, 32'h400, 32'h400};
        tbl[4] = '{32'h100, 32'h200, 32'h200, 32'h200, 4'b0001, 3, 32'h200, 32'h200};
        tbl[5] = '{0, 0, 32'h200, 32'h100, 4'b0010, 6, 32'h200, 32'h100};
        tbl[6] = '{0, 0, 32'h800, 0, 4'b0000, 3, 32'h800, 0};
        tbl[7] = '{32'h400, 0, 0, 32'h800, 4'b1000, 1, 32'h400, 0};
        tbl[8] = '{32'h400, 0, 32'h400, 32'h800, 4'b1000, 3, 32'h400, 32'h800};
        tbl[9] = '{-1024, -1024, 0, 0, 4'b1000, 4, 0, 0};

        rst       = 1;
        valid_tri = 0;
        rate_in   = 4'b1000;
        for (int v = 0; v < 3; v++) begin
            color_in[v] = '0;
            for (int a = 0; a < 3; a++) tri_in[v][a] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            box_in[k][0] = '0;
            box_in[k][1] = '0;
        end
        tick();
        tick();
        rst = 0;
        tick();

        // table of isolated boxes
        for (int i = 0; i < 10; i++) begin
            drain();
            dut_cnt = 0;
            send(tbl[i].llx, tbl[i].lly, tbl[i].urx, tbl[i].ury, tbl[i].rate);
            drain();
            cmp($sformatf("tbl%0d_count", i), dut_cnt, tbl[i].n);
            cmp($sformatf("tbl%0d_last_x", i), dut_lx, tbl[i].lx);
            cmp($sformatf("tbl%0d_last_y", i), dut_ly, tbl[i].ly);
        end

        // back-to-back: second triangle waits for the last-sample cycle
        drain();
        send(0, 0, 32'h400, 32'h400, 4'b1000);
        t0 = cyc;
        send(32'h800, 0, 32'hC00, 32'h400, 4'b1000);
        cmp("b2b_accept_gap", cyc - t0, 4);
        send(32'h400, 32'h400, 32'h400, 32'h400, 4'b1000);
        send(0, 0, 32'h400, 0, 4'b1000);
        drain();

        // reset in the middle of a 3x3 walk
        send(0, 0, 32'h800, 32'h800, 4'b1000);
        valid_tri = 0;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        tick();
        send(32'h400, 32'h400, 32'h800, 32'h800, 4'b1000);
        drain();

        // randomized boxes, with and without idle gaps
        rates[0] = 4'b1000;
        rates[1] = 4'b0100;
        rates[2] = 4'b0010;
        rates[3] = 4'b0001;
        cur_rate = 4'b1000;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] r;
            int st, llx, lly, urx, ury;
            r = rates[$urandom_range(0, 3)];
            if (r != cur_rate) begin
                drain();
                cur_rate = r;
            end
            st  = model_step(r);
            llx = st * ($urandom_range(0, 20) - 10);
            lly = st * ($urandom_range(0, 20) - 10);
            urx = llx + st * $urandom_range(0, 3);
            ury = lly + st * $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) urx = llx - st;
            if ($urandom_range(0, 7) == 0) ury = lly - st;
            send(llx, lly, urx, ury, r);
            if ($urandom_range(0, 2) == 0) begin
                valid_tri = 0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
